// File: rtl/acc_unit_if.sv
// Control <-> accumulator request/result bundle.
// master: control side (drives requests); slave: acc_unit.
interface acc_unit_if #(
  parameter int W = 8
);
  logic         op_valid;
  logic [2:0]   acc_op;
  logic [W-1:0] lut_value;
  logic [W-1:0] operand;
  logic [2:0]   shamt;
  logic         shift_right;
  logic [W-1:0] acc;
  logic         carry;
  logic         zero;
  logic         busy;
  logic         done;

  modport master (
    output op_valid, acc_op, lut_value,
    output operand, shamt, shift_right,
    input  acc, carry, zero, busy, done
  );

  modport slave (
    input  op_valid, acc_op, lut_value,
    input  operand, shamt, shift_right,
    output acc, carry, zero, busy, done
  );
endinterface

// File: rtl/acc_unit.sv
// Accumulator stage: acc + carry/zero flags, one op per accepted request.
// Ports: clk, rst_n (sync, active-low), bus (acc_unit_if.slave).
module acc_unit #(
  parameter int W = 8
) (
  input logic      clk,
  input logic      rst_n,
  acc_unit_if.slave bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_LDR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_SHF = 3'b111;

  logic [0:0]   state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         dir_q, dir_d;
  logic [W-1:0] acc_q, acc_d;
  logic         carry_q, carry_d;
  logic         done_q, done_d;

  logic [W:0]   sum;
  logic         sh_dir;
  logic [W-1:0] sh_acc;
  logic         sh_out;

  // Direction comes live from the bus on the accepting
  // edge, from the captured copy while iterating.
  assign sh_dir = (state_q == S_IDLE) ? bus.shift_right : dir_q;
  assign sh_acc = sh_dir ? (acc_q >> 1) : (acc_q << 1);
  assign sh_out = sh_dir ? acc_q[0] : acc_q[W-1];
  assign sum    = {1'b0, acc_q} + {1'b0, bus.operand};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.op_valid) begin
          done_d = 1'b1;
          unique case (bus.acc_op)
            OP_NOP: ;
            OP_LDI: acc_d = bus.lut_value;
            OP_LDR: acc_d = bus.operand;
            OP_ADD: begin
              acc_d   = sum[W-1:0];
              carry_d = sum[W];
            end
            OP_SUB: begin
              acc_d   = acc_q - bus.operand;
              carry_d = acc_q < bus.operand;
            end
            OP_AND: acc_d = acc_q & bus.operand;
            OP_XOR: acc_d = acc_q ^ bus.operand;
            OP_SHF: begin
              if (bus.shamt != 3'd0) begin
                acc_d   = sh_acc;
                carry_d = sh_out;
              end
              if (bus.shamt >= 3'd2) begin
                state_d = S_SHIFT;
                cnt_d   = bus.shamt - 3'd1;
                dir_d   = bus.shift_right;
                done_d  = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      S_SHIFT: begin
        acc_d   = sh_acc;
        carry_d = sh_out;
        cnt_d   = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      dir_q   <= 1'b0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign bus.acc   = acc_q;
  assign bus.carry = carry_q;
  assign bus.zero  = (acc_q == '0);
  assign bus.busy  = (state_q == S_SHIFT);
  assign bus.done  = done_q;

endmodule

// File: tb/tb_acc_unit.sv
// Scoreboard bench for acc_unit.
// Expected results queued at issue, compared on done.
module tb_acc_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  acc_unit_if #(.W(8)) bus ();

  acc_unit #(.W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [7:0] acc;
    logic       carry;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_acc = 8'h00;
  logic       m_c   = 1'b0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", bus.done, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("acc", bus.acc, e.acc);
        check("carry", bus.carry, e.carry);
        check("zero", bus.zero, e.acc == 8'h00);
      end
    end
  end

  task automatic model(logic [2:0] op, logic [7:0] lut,
                       logic [7:0] opd, logic [2:0] sh,
                       logic dir);
    case (op)
      3'd1: m_acc = lut;
      3'd2: m_acc = opd;
      3'd3: {m_c, m_acc} = {1'b0, m_acc} + {1'b0, opd};
      3'd4: begin
        m_c   = m_acc < opd;
        m_acc = m_acc - opd;
      end
      3'd5: m_acc = m_acc & opd;
      3'd6: m_acc = m_acc ^ opd;
      3'd7: begin
        for (int i = 0; i < int'(sh); i++) begin
          if (dir) begin
            m_c   = m_acc[0];
            m_acc = m_acc >> 1;
          end else begin
            m_c   = m_acc[7];
            m_acc = m_acc << 1;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic do_op(logic [2:0] op, logic [7:0] lut,
                       logic [7:0] opd, logic [2:0] sh,
                       logic dir);
    exp_t e;
    int n = 0;
    while (bus.busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy) check("busy_timeout", bus.busy, 0);
    bus.op_valid    = 1'b1;
    bus.acc_op      = op;
    bus.lut_value   = lut;
    bus.operand     = opd;
    bus.shamt       = sh;
    bus.shift_right = dir;
    model(op, lut, opd, sh, dir);
    e.acc   = m_acc;
    e.carry = m_c;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
  endtask

  initial begin
    int bcnt;
    int dcyc;
    bus.op_valid    = 1'b0;
    bus.acc_op      = 3'd0;
    bus.lut_value   = 8'h00;
    bus.operand     = 8'h00;
    bus.shamt       = 3'd0;
    bus.shift_right = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_acc", bus.acc, 0);
    check("rst_carry", bus.carry, 0);
    check("rst_zero", bus.zero, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    @(posedge clk); #1;

    // LDI and one-cycle done pulse
    do_op(3'd1, 8'h3F, 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    check("ldi_done", bus.done, 1);
    @(negedge clk);
    check("ldi_done_low", bus.done, 0);
    @(posedge clk); #1;

    // back-to-back: wrap-around add, then borrow
    do_op(3'd1, 8'hFF, 8'h00, 3'd0, 1'b0);
    do_op(3'd3, 8'h00, 8'h01, 3'd0, 1'b0);
    do_op(3'd4, 8'h00, 8'h01, 3'd0, 1'b0);
    do_op(3'd5, 8'h00, 8'h5A, 3'd0, 1'b0);
    do_op(3'd6, 8'h00, 8'hC3, 3'd0, 1'b0);
    do_op(3'd2, 8'h00, 8'h10, 3'd0, 1'b0);
    do_op(3'd0, 8'hAA, 8'hAA, 3'd5, 1'b1);

    // SHIFT left 3 with ADD and shift-field changes while busy
    do_op(3'd1, 8'h81, 8'h00, 3'd0, 1'b0);
    do_op(3'd7, 8'h00, 8'h00, 3'd3, 1'b0);
    bus.op_valid    = 1'b1;
    bus.acc_op      = 3'd3;
    bus.operand     = 8'h55;
    bus.shamt       = 3'd1;
    bus.shift_right = 1'b1;
    bcnt = 0;
    dcyc = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
      else bus.op_valid = 1'b0;
      if (bus.done) begin
        dcyc = i;
        break;
      end
    end
    bus.op_valid = 1'b0;
    check("shl3_busy_cycles", bcnt, 2);
    check("shl3_done_cycle", dcyc, 3);
    @(posedge clk); #1;

    // SHIFT right by 1: single-cycle, never busy
    do_op(3'd1, 8'h01, 8'h00, 3'd0, 1'b0);
    do_op(3'd7, 8'h00, 8'h00, 3'd1, 1'b1);
    @(negedge clk);
    check("shr1_busy", bus.busy, 0);
    check("shr1_done", bus.done, 1);
    @(posedge clk); #1;

    // random mix including multi-cycle shifts
    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), 8'($urandom),
            8'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)));
    end
    repeat (10) @(posedge clk);
    #1;

    // reset at the 3rd shift edge of a shamt=7 shift
    do_op(3'd1, 8'hAB, 8'h00, 3'd0, 1'b0);
    do_op(3'd7, 8'h00, 8'h00, 3'd7, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    m_acc = 8'h00;
    m_c   = 1'b0;
    @(negedge clk);
    check("mid_rst_acc", bus.acc, 0);
    check("mid_rst_carry", bus.carry, 0);
    check("mid_rst_zero", bus.zero, 1);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    repeat (8) @(posedge clk);
    #1;
    do_op(3'd1, 8'h5A, 8'h00, 3'd0, 1'b0);
    do_op(3'd3, 8'h00, 8'hA6, 3'd0, 1'b0);

    repeat (20) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_unit.md
# acc_unit

Accumulator datapath stage sitting directly downstream of `acc_lut`. Its `lut_value` input is wired to `acc_lut.value`, and its `operand` input comes from the register-file read port. It holds the architectural accumulator plus carry/zero flags and executes one accumulator op per accepted request. Shifts are iterative, one bit per cycle, with a busy/done handshake back to the control unit.

## Interface
Parameters:
- `W`, default 8: accumulator and operand width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `op_valid` in 1: request strobe from control.
- `acc_op` in 3: operation code (see Operation).
- `lut_value` in W: constant from `acc_lut.value`.
- `operand` in W: register-file read data.
- `shamt` in 3: shift amount 0–7, used only by SHIFT.
- `shift_right` in 1: SHIFT direction, 1 = logical right, 0 = left.
- `acc` out W: accumulator register.
- `carry` out 1: carry/borrow/shift-out flag.
- `zero` out 1: high when `acc == 0`; combinational from `acc`.
- `busy` out 1: high while a multi-cycle shift is in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- Acceptance: a request is accepted on a rising edge where `rst_n=1`, `op_valid=1` and `busy=0`.
  - `op_valid` while `busy=1` is ignored. There is no queueing; control must stall on `busy`.
- Opcodes (`acc_op`), each with its effect on `acc` and `carry`:
  - 000 NOP: no change.
  - 001 LDI: `acc` <= `lut_value`; `carry` unchanged.
  - 010 LDR: `acc` <= `operand`; `carry` unchanged.
  - 011 ADD: `acc` <= (`acc` + `operand`) mod 2^W; `carry` <= bit W of the W+1-bit sum.
  - 100 SUB: `acc` <= (`acc` − `operand`) mod 2^W; `carry` <= 1 iff `acc` < `operand` (unsigned borrow).
  - 101 AND: `acc` <= `acc` & `operand`; `carry` unchanged.
  - 110 XOR: `acc` <= `acc` ^ `operand`; `carry` unchanged.
  - 111 SHIFT: logical shift by `shamt`, zero-fill, one bit per edge. `carry` <= last bit shifted out (bit W−1 for left, bit 0 for right).
- SHIFT operand capture: `shamt` and `shift_right` are captured at acceptance. Later changes to these inputs have no effect.
- SHIFT with `shamt=0`: `acc` and `carry` unchanged; completes like a single-cycle op.
- FSM has two states:
  - IDLE: accepts requests.
  - SHIFTING: holds a 3-bit remaining-count register.
- Transitions:
  - IDLE → SHIFTING when SHIFT is accepted with `shamt` ≥ 2. The first bit is shifted at the acceptance edge and count <= `shamt`−1.
  - SHIFTING: each edge shifts one bit and decrements count. When count reaches 0 after that edge's shift, the FSM returns to IDLE.
  - All other accepted ops, and SHIFT with `shamt` ≤ 1, stay in IDLE.
- Reset (any state, including mid-shift) forces:
  - `acc`=0, `carry`=0, `zero`=1, `busy`=0, `done`=0, state IDLE.
  - The partial shift is abandoned and no `done` pulse is produced.

## Timing
- Single-cycle ops (everything except SHIFT with `shamt` ≥ 2):
  - Accepted at edge k; the result is visible on `acc`/`carry`/`zero` after edge k.
  - `done`=1 for exactly the cycle following edge k.
- SHIFT with N=`shamt` ≥ 2:
  - `acc` is updated at edges k … k+N−1.
  - `busy`=1 from after edge k until after edge k+N−2, i.e. N−1 cycles.
  - `done`=1 for the single cycle after edge k+N−1. `busy` is 0 in that cycle.
- Back-to-back requests:
  - A new request is acceptable in the same cycle `done` is high.
  - For single-cycle ops, throughput is one op per cycle.
- `lut_value` and `operand` are sampled only at the acceptance edge.
- `done` is registered; `busy` is decoded from the state register. Neither has a combinational path from inputs.

## Test plan
- Reset, then LDI with `lut_value`=0x3F → `acc`=0x3F, `zero`=0, `carry`=0, `done` pulses 1 cycle.
- `acc`=0xFF, ADD `operand`=0x01 → `acc`=0x00, `carry`=1, `zero`=1. Then SUB `operand`=0x01 → `acc`=0xFF, `carry`=1 (borrow).
- `acc`=0x81, SHIFT left `shamt`=3 → `busy` high for 2 cycles, `acc`=0x08, `carry`=0, `done` on the 3rd cycle after acceptance.
- Assert `op_valid` with ADD while `busy` → ignored; `acc` is unaffected except for the shift.
- `acc`=0x01, SHIFT right `shamt`=1 → `acc`=0x00, `carry`=1, `busy` never high, `done` next cycle.
- SHIFT `shamt`=7 in progress; drive `rst_n`=0 for one edge at the 3rd shift cycle → all outputs at reset values, no `done`. The next LDI then works normally.
